// File: rtl/imem_prog_loader.sv
// Instruction-memory loader: editable instruction store with a stepped program
// cursor, programmed-length tracking and a PROG/RUN gate in front of CPU fetch.
module imem_prog_loader #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 64,
  parameter int unsigned     AW        = $clog2(DEPTH),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            up,
  input  logic            down,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_instr,
  input  logic            auto_inc,
  input  logic            clear_prog,
  input  logic [XLEN-1:0] fetch_addr,
  output logic [XLEN-1:0] fetch_instr,
  output logic            fetch_fault,
  output logic            run,
  output logic [AW-1:0]   cursor,
  output logic [XLEN-1:0] cursor_instr,
  output logic [AW:0]     prog_len
);

  typedef enum logic {
    ST_PROG = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [XLEN-1:0] mem [DEPTH];

  logic            up_q;
  logic            down_q;
  logic            in_prog;
  logic            up_rise;
  logic            down_rise;
  logic            clr_acc;
  logic            wr_acc;
  logic            mem_we;
  logic [AW:0]     cursor_plus1;
  logic [AW-1:0]   cursor_next;
  logic [AW:0]     prog_len_next;

  logic [AW-1:0]   fetch_idx;
  logic            fetch_aligned;
  logic            fetch_in_range;
  logic            fetch_programmed;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_PROG;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start level selects RUN, its absence returns to PROG
  always_comb begin
    state_next = state;
    case (state)
      ST_PROG: if (start)  state_next = ST_RUN;
      ST_RUN:  if (!start) state_next = ST_PROG;
      default: state_next = ST_PROG;
    endcase
  end

  // FSM outputs (decoded straight from the state register)
  always_comb begin
    run     = 1'b0;
    in_prog = 1'b1;
    if (state == ST_RUN) begin
      run     = 1'b1;
      in_prog = 1'b0;
    end
  end

  // Edit controls: clear beats write, an accepted write swallows step edges
  always_comb begin
    up_rise       = up & ~up_q;
    down_rise     = down & ~down_q;
    clr_acc       = in_prog & clear_prog;
    wr_acc        = in_prog & wr_en & ~clear_prog;
    // The memory has no reset; gating with reset drops writes while it is held
    mem_we        = wr_acc & reset;
    cursor_plus1  = {1'b0, cursor} + (AW + 1)'(1);
    cursor_next   = cursor;
    prog_len_next = prog_len;
    if (clr_acc) begin
      cursor_next   = '0;
      prog_len_next = '0;
    end else if (wr_acc) begin
      if (auto_inc) cursor_next = cursor + AW'(1);
      if (cursor_plus1 > prog_len) prog_len_next = cursor_plus1;
    end else if (in_prog && up_rise && !down_rise) begin
      cursor_next = cursor + AW'(1);
    end else if (in_prog && down_rise && !up_rise) begin
      cursor_next = cursor - AW'(1);
    end
  end

  // Cursor, length, readback and edge-detect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor       <= '0;
      prog_len     <= '0;
      cursor_instr <= '0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
    end else begin
      cursor       <= cursor_next;
      prog_len     <= prog_len_next;
      cursor_instr <= mem[cursor_next];
      up_q         <= up;
      down_q       <= down;
    end
  end

  // Instruction store write port
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cursor] <= wr_instr;
    end
  end

  // Fetch port: NOP unless running on an aligned, in-range, programmed word
  always_comb begin
    fetch_idx        = fetch_addr[AW+1:2];
    fetch_aligned    = (fetch_addr[1:0] == 2'b00);
    fetch_in_range   = (fetch_addr[XLEN-1:AW+2] == '0);
    fetch_programmed = ({1'b0, fetch_idx} < prog_len);
    fetch_instr      = NOP_INSTR;
    fetch_fault      = run & ~(fetch_aligned & fetch_in_range);
    if (run && fetch_aligned && fetch_in_range && fetch_programmed) begin
      fetch_instr = mem[fetch_idx];
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: a vector table for the single-cycle
// behaviour plus hand-written sequences for multi-cycle corner cases.
module tb_imem_prog_loader;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic            clk;
  logic            reset;
  logic            start;
  logic            up;
  logic            down;
  logic            wr_en;
  logic [XLEN-1:0] wr_instr;
  logic            auto_inc;
  logic            clear_prog;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] fetch_instr;
  logic            fetch_fault;
  logic            run;
  logic [AW-1:0]   cursor;
  logic [XLEN-1:0] cursor_instr;
  logic [AW:0]     prog_len;

  imem_prog_loader #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .up(up), .down(down),
    .wr_en(wr_en), .wr_instr(wr_instr), .auto_inc(auto_inc),
    .clear_prog(clear_prog), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_fault(fetch_fault), .run(run),
    .cursor(cursor), .cursor_instr(cursor_instr), .prog_len(prog_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        up;
    logic        down;
    logic        wr_en;
    logic        auto_inc;
    logic        clear_prog;
    logic [31:0] wr_instr;
    logic [31:0] fetch_addr;
    logic        exp_run;
    logic [31:0] exp_cursor;
    logic [31:0] exp_plen;
    logic [31:0] exp_fi;
    logic        exp_ff;
  } vec_t;

  vec_t vq[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic st, input logic u, input logic d, input logic we,
                     input logic ai, input logic clr, input logic [31:0] wi,
                     input logic [31:0] fa, input logic er, input int ec,
                     input int ep, input logic [31:0] efi, input logic eff);
    vec_t v;
    v.start = st; v.up = u; v.down = d; v.wr_en = we; v.auto_inc = ai;
    v.clear_prog = clr; v.wr_instr = wi; v.fetch_addr = fa; v.exp_run = er;
    v.exp_cursor = 32'(ec); v.exp_plen = 32'(ep); v.exp_fi = efi; v.exp_ff = eff;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    up = 1'b0; down = 1'b0; wr_en = 1'b0; auto_inc = 1'b0;
    clear_prog = 1'b0; wr_instr = '0; fetch_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_up();
    up = 1'b1; step(); up = 1'b0; step();
  endtask

  task automatic pulse_down();
    down = 1'b1; step(); down = 1'b0; step();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; start = 1'b0;
    idle_inputs();

    //  st u  d  we ai clr wr_instr      fetch    run cur plen fetch_instr   fault
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,   1,  0,  0,  NOP,          0); // run from empty
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  0,  NOP,          0);
    add(0, 0, 0, 1, 1, 0, 32'h00AE0E13, 32'h0,   0,  1,  1,  NOP,          0);
    add(0, 0, 0, 1, 1, 0, 32'h00100093, 32'h0,   0,  2,  2,  NOP,          0);
    add(0, 0, 0, 1, 1, 0, 32'h00208133, 32'h0,   0,  3,  3,  NOP,          0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0,  3,  3,  NOP,          0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h8,   1,  3,  3,  32'h00208133, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'hC,   1,  3,  3,  NOP,          0); // past prog_len
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,   1,  3,  3,  32'h00AE0E13, 0);
    add(1, 1, 0, 1, 1, 1, 32'hFFFFFFFF, 32'h2,   1,  3,  3,  NOP,          1); // edits ignored, misaligned
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h100, 1,  3,  3,  NOP,          1); // 4*DEPTH out of range
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h8,   1,  3,  3,  32'h00208133, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h4,   1,  3,  3,  32'h00100093, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'hFC,  1,  3,  3,  NOP,          0); // unprogrammed, no fault
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h2,   0,  3,  3,  NOP,          0); // no fault in PROG
    add(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   0,  0,  0,  NOP,          0); // clear
    add(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,   0, 63,  0,  NOP,          0); // 0-1 wraps
    add(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,   0, 63,  0,  NOP,          0);
    add(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,   0, 63,  0,  NOP,          0);
    add(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,   0, 63,  0,  NOP,          0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0, 63,  0,  NOP,          0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  0,  NOP,          0); // 63+1 wraps
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  0,  NOP,          0);
    add(0, 1, 1, 0, 0, 0, 32'h0,        32'h0,   0,  0,  0,  NOP,          0); // both rise: hold
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  0,  NOP,          0);
    add(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,   0, 63,  0,  NOP,          0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0, 63,  0,  NOP,          0);
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  0,  NOP,          0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  0,  NOP,          0);
    add(0, 1, 0, 1, 0, 0, 32'h11111111, 32'h0,   0,  0,  1,  NOP,          0); // up lost in write
    add(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  1,  NOP,          0); // held level: no step
    add(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   0,  0,  1,  NOP,          0);

    // Reset state
    #12;
    check("rst_run", 32'(run), 32'h0);
    check("rst_cursor", 32'(cursor), 32'h0);
    check("rst_prog_len", 32'(prog_len), 32'h0);
    check("rst_cursor_instr", cursor_instr, 32'h0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();

    foreach (vq[i]) begin
      start = vq[i].start; up = vq[i].up; down = vq[i].down; wr_en = vq[i].wr_en;
      auto_inc = vq[i].auto_inc; clear_prog = vq[i].clear_prog;
      wr_instr = vq[i].wr_instr; fetch_addr = vq[i].fetch_addr;
      step();
      check($sformatf("v%0d_run", i), 32'(run), 32'(vq[i].exp_run));
      check($sformatf("v%0d_cursor", i), 32'(cursor), vq[i].exp_cursor);
      check($sformatf("v%0d_prog_len", i), 32'(prog_len), vq[i].exp_plen);
      check($sformatf("v%0d_fetch_instr", i), fetch_instr, vq[i].exp_fi);
      check($sformatf("v%0d_fetch_fault", i), 32'(fetch_fault), 32'(vq[i].exp_ff));
    end
    start = 1'b0;
    idle_inputs();

    // Non-incrementing write at cursor 5, then readback
    repeat (5) pulse_up();
    check("seq_cursor5", 32'(cursor), 32'd5);
    wr_en = 1'b1; wr_instr = 32'hDEADBEEF; step();
    wr_en = 1'b0;
    check("seq_plen6", 32'(prog_len), 32'd6);
    check("seq_cursor_hold", 32'(cursor), 32'd5);
    step();
    check("seq_readback", cursor_instr, 32'hDEADBEEF);

    // A write below the current length leaves the length alone
    repeat (3) pulse_down();
    wr_en = 1'b1; wr_instr = 32'hAAAA0002; step();
    wr_en = 1'b0;
    check("seq_plen_max", 32'(prog_len), 32'd6);
    check("seq_cursor2", 32'(cursor), 32'd2);

    // Clear wins over a simultaneous write and step
    clear_prog = 1'b1; wr_en = 1'b1; up = 1'b1; wr_instr = 32'hCAFEF00D; step();
    clear_prog = 1'b0; wr_en = 1'b0; up = 1'b0;
    check("seq_clr_plen", 32'(prog_len), 32'd0);
    check("seq_clr_cursor", 32'(cursor), 32'd0);
    step();

    // Writing the last word gives the full length and wraps the cursor
    pulse_down();
    wr_en = 1'b1; auto_inc = 1'b1; wr_instr = 32'h0000A063; step();
    wr_en = 1'b0; auto_inc = 1'b0;
    check("seq_plen_full", 32'(prog_len), 32'd64);
    check("seq_cursor_wrap", 32'(cursor), 32'd0);
    start = 1'b1; fetch_addr = 32'hFC; step();
    check("seq_fetch_last", fetch_instr, 32'h0000A063);
    check("seq_fault_last", 32'(fetch_fault), 32'h0);
    fetch_addr = 32'h14; #1;
    check("seq_fetch_5", fetch_instr, 32'hDEADBEEF);
    fetch_addr = 32'h100; #1;
    check("seq_fault_oob", 32'(fetch_fault), 32'h1);
    check("seq_fetch_oob", fetch_instr, NOP);
    start = 1'b0; fetch_addr = '0; step();

    // Known word at index 0 for the reset test
    wr_en = 1'b1; wr_instr = 32'h12345678; step();
    wr_en = 1'b0; step();
    check("seq_readback0", cursor_instr, 32'h12345678);

    // Asynchronous reset mid-RUN with a write pending
    start = 1'b1; step();
    check("seq_run_pre_rst", 32'(run), 32'h1);
    wr_en = 1'b1; wr_instr = 32'hBAD0BAD0; #2;
    reset = 1'b0; #1;
    check("arst_run", 32'(run), 32'h0);
    check("arst_cursor", 32'(cursor), 32'h0);
    check("arst_prog_len", 32'(prog_len), 32'h0);
    check("arst_cursor_instr", cursor_instr, 32'h0);
    start = 1'b0;
    step();
    step();
    wr_en = 1'b0; #2;
    reset = 1'b1;
    step();
    step();
    check("arst_no_write", cursor_instr, 32'h12345678);
    check("arst_plen_after", 32'(prog_len), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so a stalled run still ends with a report
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
